sal_bk_ctrl: RTL and testbench

- Per-bank DRAM controller; one instance per bank, sitting directly upstream of the command scheduler.
- Accepts decoded requests (read or write; row, column, ID, burst length) for its bank.
- Tracks open-row state and intra-bank timing (tRCD, tRAS, tRP, tRTP, tWR, tRFC).
- Raises exactly one of act/rd/wr/pre/ref requests toward the scheduler and advances on the returned grant.

---
 rtl/sal_bk_pkg.sv | 17 +
 rtl/sal_bk_ctrl_if.sv | 68 ++++++
 rtl/sal_bk_ctrl_chk.sv | 15 +
 rtl/sal_bk_ctrl_timing_cntr.sv | 31 +++
 rtl/sal_bk_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_sal_bk_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/sal_bk_pkg.sv
// Shared types and default widths for the per-bank DRAM controller.
package sal_bk_pkg;

    localparam int RA_W           = 16;
    localparam int CA_W           = 10;
    localparam int ID_W           = 4;
    localparam int LEN_W          = 4;
    localparam int TW_W           = 8;
    localparam int PAGE_TIMEOUT_D = 32;

    // Bank row state: CLOSED means precharged, OPEN means one row is active.
    typedef enum logic [0:0] {
        CLOSED = 1'b0,
        OPEN   = 1'b1
    } bk_state_e;

endpackage

// File: rtl/sal_bk_ctrl_if.sv
// Request / timing / scheduler-command bundle for one bank controller.
// slave  : the bank controller side.
// master : the request source + scheduler side.
interface sal_bk_ctrl_if
    import sal_bk_pkg::*;
#(
    parameter int RA_WIDTH  = RA_W,
    parameter int CA_WIDTH  = CA_W,
    parameter int ID_WIDTH  = ID_W,
    parameter int LEN_WIDTH = LEN_W,
    parameter int TW        = TW_W
) ();

    logic                 req_valid_i;
    logic                 req_wr_i;
    logic [RA_WIDTH-1:0]  req_ra_i;
    logic [CA_WIDTH-1:0]  req_ca_i;
    logic [ID_WIDTH-1:0]  req_id_i;
    logic [LEN_WIDTH-1:0] req_len_i;
    logic                 req_ready_o;

    logic                 ref_pend_i;
    logic                 ref_done_o;

    logic [TW-1:0]        t_rcd_m1_i;
    logic [TW-1:0]        t_ras_m1_i;
    logic [TW-1:0]        t_rp_m1_i;
    logic [TW-1:0]        t_rtp_m1_i;
    logic [TW-1:0]        t_wr_m1_i;
    logic [TW-1:0]        t_rfc_m1_i;

    logic                 act_req_o;
    logic                 rd_req_o;
    logic                 wr_req_o;
    logic                 pre_req_o;
    logic                 ref_req_o;
    logic [RA_WIDTH-1:0]  ra_o;
    logic [CA_WIDTH-1:0]  ca_o;
    logic [ID_WIDTH-1:0]  id_o;
    logic [LEN_WIDTH-1:0] len_o;

    logic                 act_gnt_i;
    logic                 rd_gnt_i;
    logic                 wr_gnt_i;
    logic                 pre_gnt_i;
    logic                 ref_gnt_i;

    modport slave (
        input  req_valid_i, req_wr_i, req_ra_i, req_ca_i, req_id_i, req_len_i,
        input  ref_pend_i,
        input  t_rcd_m1_i, t_ras_m1_i, t_rp_m1_i, t_rtp_m1_i, t_wr_m1_i, t_rfc_m1_i,
        input  act_gnt_i, rd_gnt_i, wr_gnt_i, pre_gnt_i, ref_gnt_i,
        output req_ready_o, ref_done_o,
        output act_req_o, rd_req_o, wr_req_o, pre_req_o, ref_req_o,
        output ra_o, ca_o, id_o, len_o
    );

    modport master (
        output req_valid_i, req_wr_i, req_ra_i, req_ca_i, req_id_i, req_len_i,
        output ref_pend_i,
        output t_rcd_m1_i, t_ras_m1_i, t_rp_m1_i, t_rtp_m1_i, t_wr_m1_i, t_rfc_m1_i,
        output act_gnt_i, rd_gnt_i, wr_gnt_i, pre_gnt_i, ref_gnt_i,
        input  req_ready_o, ref_done_o,
        input  act_req_o, rd_req_o, wr_req_o, pre_req_o, ref_req_o,
        input  ra_o, ca_o, id_o, len_o
    );

endinterface

// File: rtl/sal_bk_ctrl_chk.sv
// Protocol checker for the bank controller's scheduler port.
module sal_bk_ctrl_chk (
    input logic       clk,
    input logic       rst_n,
    input logic [4:0] i_req,
    input logic [4:0] i_gnt
);

    // The scheduler may return at most one grant per cycle.
    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(i_gnt));

    // The controller raises at most one command request per cycle.
    a_req_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(i_req));

endmodule

// File: rtl/sal_bk_ctrl_timing_cntr.sv
// sal_timing_cntr: load-on-event, saturating down-counter for one DRAM
// timing constraint. Loading m1 at event cycle c makes o_is_zero true
// again at cycle c+t.
module sal_timing_cntr #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [TW-1:0] i_load_val,
    output logic          o_is_zero
);

    logic [TW-1:0] r_cnt;

    // Load on event, otherwise count down and hold at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {TW{1'b0}};
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != {TW{1'b0}}) begin
            r_cnt <= r_cnt - TW'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_is_zero = (r_cnt == {TW{1'b0}});

endmodule

// File: rtl/sal_bk_ctrl.sv
// sal_bk_ctrl: per-bank DRAM controller. Tracks the open row and intra-bank
// timing and raises one of ACT/RD/WR/PRE/REF toward the scheduler.
// Optional idle-page auto-close is built when SAL_BK_PAGE_TIMEOUT_EN is
// defined; otherwise the bank follows an open-page policy.
module sal_bk_ctrl
    import sal_bk_pkg::*;
#(
    parameter int RA_WIDTH     = RA_W,
    parameter int CA_WIDTH     = CA_W,
    parameter int ID_WIDTH     = ID_W,
    parameter int LEN_WIDTH    = LEN_W,
    parameter int TW           = TW_W,
    parameter int PAGE_TIMEOUT = PAGE_TIMEOUT_D
) (
    input logic          clk,
    input logic          rst_n,
    sal_bk_ctrl_if.slave bus
);

    if (PAGE_TIMEOUT < 1) begin : g_bad_page_timeout
        $error("sal_bk_ctrl: PAGE_TIMEOUT must be at least 1");
    end

    bk_state_e            r_state;
    bk_state_e            w_state_nxt;
    logic [RA_WIDTH-1:0]  r_open_ra;

    logic w_rcd_met, w_ras_met, w_rp_met, w_rtp_met, w_wr_met, w_rfc_met;
    logic w_act_req, w_rd_req, w_wr_req, w_pre_req, w_ref_req;
    logic w_act_fire, w_rd_fire, w_wr_fire, w_pre_fire, w_ref_fire;
    logic w_hit, w_close_ok, w_idle_close;
    logic [RA_WIDTH-1:0]  w_ra;
    logic [CA_WIDTH-1:0]  w_ca;
    logic [ID_WIDTH-1:0]  w_id;
    logic [LEN_WIDTH-1:0] w_len;

    // ---------------- timing counters ----------------
    sal_timing_cntr #(.TW(TW)) u_rcd (.clk(clk), .rst_n(rst_n), .i_load(w_act_fire),
                                      .i_load_val(bus.t_rcd_m1_i), .o_is_zero(w_rcd_met));
    sal_timing_cntr #(.TW(TW)) u_ras (.clk(clk), .rst_n(rst_n), .i_load(w_act_fire),
                                      .i_load_val(bus.t_ras_m1_i), .o_is_zero(w_ras_met));
    sal_timing_cntr #(.TW(TW)) u_rp  (.clk(clk), .rst_n(rst_n), .i_load(w_pre_fire),
                                      .i_load_val(bus.t_rp_m1_i),  .o_is_zero(w_rp_met));
    sal_timing_cntr #(.TW(TW)) u_rtp (.clk(clk), .rst_n(rst_n), .i_load(w_rd_fire),
                                      .i_load_val(bus.t_rtp_m1_i), .o_is_zero(w_rtp_met));
    sal_timing_cntr #(.TW(TW)) u_wr  (.clk(clk), .rst_n(rst_n), .i_load(w_wr_fire),
                                      .i_load_val(bus.t_wr_m1_i),  .o_is_zero(w_wr_met));
    sal_timing_cntr #(.TW(TW)) u_rfc (.clk(clk), .rst_n(rst_n), .i_load(w_ref_fire),
                                      .i_load_val(bus.t_rfc_m1_i), .o_is_zero(w_rfc_met));

`ifdef SAL_BK_PAGE_TIMEOUT_EN
    localparam int IDLE_W = $clog2(PAGE_TIMEOUT + 1);
    logic [IDLE_W-1:0] r_idle_cnt;
    logic              w_any_gnt;

    assign w_any_gnt = bus.act_gnt_i | bus.rd_gnt_i | bus.wr_gnt_i | bus.pre_gnt_i | bus.ref_gnt_i;

    // Count idle cycles of an open page; any activity restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= {IDLE_W{1'b0}};
        end else if ((r_state != OPEN) || bus.req_valid_i || w_any_gnt) begin
            r_idle_cnt <= {IDLE_W{1'b0}};
        end else if (r_idle_cnt != IDLE_W'(PAGE_TIMEOUT)) begin
            r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
        end else begin
            r_idle_cnt <= r_idle_cnt;
        end
    end

    assign w_idle_close = (r_idle_cnt == IDLE_W'(PAGE_TIMEOUT));
`else
    assign w_idle_close = 1'b0;
`endif

    assign w_hit      = (bus.req_ra_i == r_open_ra);
    assign w_close_ok = w_ras_met & w_rtp_met & w_wr_met;

    // Command selection, grant qualification and next-state decode.
    // Everything is forced low while rst_n is asserted so the scheduler
    // sees an idle bank immediately.
    always_comb begin
        w_act_req   = 1'b0;
        w_rd_req    = 1'b0;
        w_wr_req    = 1'b0;
        w_pre_req   = 1'b0;
        w_ref_req   = 1'b0;
        w_ra        = {RA_WIDTH{1'b0}};
        w_ca        = {CA_WIDTH{1'b0}};
        w_id        = {ID_WIDTH{1'b0}};
        w_len       = {LEN_WIDTH{1'b0}};
        w_state_nxt = r_state;
        if (rst_n) begin
            case (r_state)
                CLOSED: begin
                    if (bus.ref_pend_i && w_rp_met && w_rfc_met) begin
                        w_ref_req = 1'b1;
                    end else if (bus.req_valid_i && w_rp_met && w_rfc_met) begin
                        w_act_req = 1'b1;
                        w_ra      = bus.req_ra_i;
                    end else begin
                        w_act_req = 1'b0;
                    end
                end
                OPEN: begin
                    if (bus.ref_pend_i) begin
                        // Close the page for refresh; new column commands wait.
                        w_pre_req = w_close_ok;
                    end else if (bus.req_valid_i && w_hit) begin
                        if (w_rcd_met) begin
                            w_wr_req = bus.req_wr_i;
                            w_rd_req = ~bus.req_wr_i;
                            w_ca     = bus.req_ca_i;
                            w_id     = bus.req_id_i;
                            w_len    = bus.req_len_i;
                        end else begin
                            w_rd_req = 1'b0;
                        end
                    end else if (bus.req_valid_i) begin
                        w_pre_req = w_close_ok;
                    end else begin
                        w_pre_req = w_idle_close & w_close_ok;
                    end
                end
                default: begin
                    w_state_nxt = CLOSED;
                end
            endcase
        end else begin
            w_state_nxt = CLOSED;
        end

        // Grants without their own request are ignored.
        w_act_fire = bus.act_gnt_i & w_act_req;
        w_rd_fire  = bus.rd_gnt_i  & w_rd_req;
        w_wr_fire  = bus.wr_gnt_i  & w_wr_req;
        w_pre_fire = bus.pre_gnt_i & w_pre_req;
        w_ref_fire = bus.ref_gnt_i & w_ref_req;

        if (w_act_fire) begin
            w_state_nxt = OPEN;
        end else if (w_pre_fire) begin
            w_state_nxt = CLOSED;
        end else begin
            w_state_nxt = w_state_nxt;
        end
    end

    // Bank state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CLOSED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the activated row on the ACT grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_open_ra <= {RA_WIDTH{1'b0}};
        end else if (w_act_fire) begin
            r_open_ra <= bus.req_ra_i;
        end else begin
            r_open_ra <= r_open_ra;
        end
    end

    assign bus.act_req_o   = w_act_req;
    assign bus.rd_req_o    = w_rd_req;
    assign bus.wr_req_o    = w_wr_req;
    assign bus.pre_req_o   = w_pre_req;
    assign bus.ref_req_o   = w_ref_req;
    assign bus.ra_o        = w_ra;
    assign bus.ca_o        = w_ca;
    assign bus.id_o        = w_id;
    assign bus.len_o       = w_len;
    assign bus.req_ready_o = w_rd_fire | w_wr_fire;
    assign bus.ref_done_o  = w_ref_fire;

    sal_bk_ctrl_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .i_req ({w_act_req, w_rd_req, w_wr_req, w_pre_req, w_ref_req}),
        .i_gnt ({bus.act_gnt_i, bus.rd_gnt_i, bus.wr_gnt_i, bus.pre_gnt_i, bus.ref_gnt_i})
    );

endmodule

// File: tb/tb_sal_bk_ctrl.sv
// Directed bench for sal_bk_ctrl. Command vector order: {act, rd, wr, pre, ref}.
module tb_sal_bk_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    sal_bk_ctrl_if bus ();

    sal_bk_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    wire [4:0] w_cmds = {bus.act_req_o, bus.rd_req_o, bus.wr_req_o, bus.pre_req_o, bus.ref_req_o};

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input logic v, input logic wr, input logic [15:0] ra,
                           input logic [9:0] ca, input logic [3:0] id, input logic [3:0] len);
        bus.req_valid_i = v;
        bus.req_wr_i    = wr;
        bus.req_ra_i    = ra;
        bus.req_ca_i    = ca;
        bus.req_id_i    = id;
        bus.req_len_i   = len;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_req(1'b1, 1'b0, 16'h0012, 10'h000, 4'h0, 4'h0);
        bus.ref_pend_i = 1'b1;
        settle();
        n_checks++;
        if (w_cmds !== 5'b00000) begin
            n_errors++; $display("FAIL reset_cmds got %b exp %b", w_cmds, 5'b00000);
        end
        n_checks++;
        if ({bus.req_ready_o, bus.ref_done_o} !== 2'b00) begin
            n_errors++; $display("FAIL reset_ready_done got %b exp %b", {bus.req_ready_o, bus.ref_done_o}, 2'b00);
        end
        next_cycle();
        next_cycle();
        set_req(1'b0, 1'b0, 16'h0000, 10'h000, 4'h0, 4'h0);
        bus.ref_pend_i = 1'b0;
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_stray_grant();
        bus.act_gnt_i = 1'b1;
        settle();
        n_checks++;
        if (bus.req_ready_o !== 1'b0) begin
            n_errors++; $display("FAIL stray_act_gnt_ready got %b exp %b", bus.req_ready_o, 1'b0);
        end
        next_cycle();
        bus.act_gnt_i = 1'b0;
        bus.rd_gnt_i  = 1'b1;
        settle();
        n_checks++;
        if (bus.req_ready_o !== 1'b0) begin
            n_errors++; $display("FAIL stray_rd_gnt_ready got %b exp %b", bus.req_ready_o, 1'b0);
        end
        next_cycle();
        bus.rd_gnt_i = 1'b0;
        next_cycle();
    endtask

    task automatic test_read_closed();
        set_req(1'b1, 1'b0, 16'h0012, 10'h005, 4'h3, 4'h2);
        settle();
        n_checks++;
        if (w_cmds !== 5'b10000 || bus.ra_o !== 16'h0012) begin
            n_errors++; $display("FAIL rd_closed_act got %b/%h exp %b/%h", w_cmds, bus.ra_o, 5'b10000, 16'h0012);
        end
        bus.act_gnt_i = 1'b1;
        next_cycle();
        bus.act_gnt_i = 1'b0;
        for (int c = 1; c < 4; c++) begin
            settle();
            n_checks++;
            if (w_cmds !== 5'b00000) begin
                n_errors++; $display("FAIL rd_closed_trcd_wait c=%0d got %b exp %b", c, w_cmds, 5'b00000);
            end
            next_cycle();
        end
        settle();
        n_checks++;
        if (w_cmds !== 5'b01000 || {bus.ca_o, bus.id_o, bus.len_o} !== {10'h005, 4'h3, 4'h2}) begin
            n_errors++; $display("FAIL rd_closed_rd got %b/%h/%h/%h exp %b/005/3/2",
                                 w_cmds, bus.ca_o, bus.id_o, bus.len_o, 5'b01000);
        end
        bus.rd_gnt_i = 1'b1;
        settle();
        n_checks++;
        if (bus.req_ready_o !== 1'b1) begin
            n_errors++; $display("FAIL rd_closed_ready got %b exp %b", bus.req_ready_o, 1'b1);
        end
        next_cycle();
        bus.rd_gnt_i = 1'b0;
    endtask

    task automatic test_row_hit();
        set_req(1'b1, 1'b0, 16'h0012, 10'h007, 4'h4, 4'h1);
        settle();
        n_checks++;
        if (w_cmds !== 5'b01000 || bus.ca_o !== 10'h007) begin
            n_errors++; $display("FAIL row_hit_rd got %b/%h exp %b/%h", w_cmds, bus.ca_o, 5'b01000, 10'h007);
        end
        bus.rd_gnt_i = 1'b1;
        settle();
        n_checks++;
        if (bus.req_ready_o !== 1'b1) begin
            n_errors++; $display("FAIL row_hit_ready got %b exp %b", bus.req_ready_o, 1'b1);
        end
        next_cycle();
        bus.rd_gnt_i = 1'b0;
    endtask

    task automatic test_row_miss();
        set_req(1'b1, 1'b1, 16'h0012, 10'h00a, 4'h5, 4'h3);
        settle();
        n_checks++;
        if (w_cmds !== 5'b00100 || bus.id_o !== 4'h5) begin
            n_errors++; $display("FAIL miss_wr_hit got %b/%h exp %b/%h", w_cmds, bus.id_o, 5'b00100, 4'h5);
        end
        bus.wr_gnt_i = 1'b1;
        settle();
        n_checks++;
        if (bus.req_ready_o !== 1'b1) begin
            n_errors++; $display("FAIL miss_wr_ready got %b exp %b", bus.req_ready_o, 1'b1);
        end
        next_cycle();
        bus.wr_gnt_i = 1'b0;
        set_req(1'b1, 1'b0, 16'h0034, 10'h001, 4'h6, 4'h0);
        for (int k = 1; k < 10; k++) begin
            settle();
            n_checks++;
            if (w_cmds !== 5'b00000) begin
                n_errors++; $display("FAIL miss_twr_wait k=%0d got %b exp %b", k, w_cmds, 5'b00000);
            end
            next_cycle();
        end
        settle();
        n_checks++;
        if (w_cmds !== 5'b00010) begin
            n_errors++; $display("FAIL miss_pre got %b exp %b", w_cmds, 5'b00010);
        end
        bus.pre_gnt_i = 1'b1;
        settle();
        n_checks++;
        if (bus.req_ready_o !== 1'b0) begin
            n_errors++; $display("FAIL miss_pre_ready got %b exp %b", bus.req_ready_o, 1'b0);
        end
        next_cycle();
        bus.pre_gnt_i = 1'b0;
        for (int k = 1; k < 3; k++) begin
            settle();
            n_checks++;
            if (w_cmds !== 5'b00000) begin
                n_errors++; $display("FAIL miss_trp_wait k=%0d got %b exp %b", k, w_cmds, 5'b00000);
            end
            next_cycle();
        end
        settle();
        n_checks++;
        if (w_cmds !== 5'b10000 || bus.ra_o !== 16'h0034) begin
            n_errors++; $display("FAIL miss_act got %b/%h exp %b/%h", w_cmds, bus.ra_o, 5'b10000, 16'h0034);
        end
        bus.act_gnt_i = 1'b1;
        next_cycle();
        bus.act_gnt_i = 1'b0;
    endtask

    task automatic test_refresh();
        set_req(1'b1, 1'b0, 16'h0034, 10'h00b, 4'h7, 4'h0);
        bus.ref_pend_i = 1'b1;
        for (int k = 1; k < 8; k++) begin
            settle();
            n_checks++;
            if (w_cmds !== 5'b00000) begin
                n_errors++; $display("FAIL ref_tras_wait k=%0d got %b exp %b", k, w_cmds, 5'b00000);
            end
            next_cycle();
        end
        settle();
        n_checks++;
        if (w_cmds !== 5'b00010) begin
            n_errors++; $display("FAIL ref_pre got %b exp %b", w_cmds, 5'b00010);
        end
        bus.pre_gnt_i = 1'b1;
        next_cycle();
        bus.pre_gnt_i = 1'b0;
        for (int k = 1; k < 3; k++) begin
            settle();
            n_checks++;
            if (w_cmds !== 5'b00000) begin
                n_errors++; $display("FAIL ref_trp_wait k=%0d got %b exp %b", k, w_cmds, 5'b00000);
            end
            next_cycle();
        end
        settle();
        n_checks++;
        if (w_cmds !== 5'b00001) begin
            n_errors++; $display("FAIL ref_req got %b exp %b", w_cmds, 5'b00001);
        end
        bus.ref_gnt_i = 1'b1;
        settle();
        n_checks++;
        if (bus.ref_done_o !== 1'b1 || bus.req_ready_o !== 1'b0) begin
            n_errors++; $display("FAIL ref_done got %b/%b exp 1/0", bus.ref_done_o, bus.req_ready_o);
        end
        next_cycle();
        bus.ref_gnt_i  = 1'b0;
        bus.ref_pend_i = 1'b0;
        settle();
        n_checks++;
        if (bus.ref_done_o !== 1'b0) begin
            n_errors++; $display("FAIL ref_done_pulse got %b exp %b", bus.ref_done_o, 1'b0);
        end
        for (int k = 1; k < 20; k++) begin
            settle();
            n_checks++;
            if (w_cmds !== 5'b00000) begin
                n_errors++; $display("FAIL ref_trfc_wait k=%0d got %b exp %b", k, w_cmds, 5'b00000);
            end
            next_cycle();
        end
        settle();
        n_checks++;
        if (w_cmds !== 5'b10000 || bus.ra_o !== 16'h0034) begin
            n_errors++; $display("FAIL ref_act_after_trfc got %b/%h exp %b/%h", w_cmds, bus.ra_o, 5'b10000, 16'h0034);
        end
        bus.act_gnt_i = 1'b1;
        next_cycle();
        bus.act_gnt_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int k = 1; k < 4; k++) begin
            next_cycle();
        end
        settle();
        n_checks++;
        if (w_cmds !== 5'b01000) begin
            n_errors++; $display("FAIL mid_pre_reset_rd got %b exp %b", w_cmds, 5'b01000);
        end
        rst_n = 1'b0;
        settle();
        n_checks++;
        if (w_cmds !== 5'b00000 || bus.req_ready_o !== 1'b0 || bus.ref_done_o !== 1'b0) begin
            n_errors++; $display("FAIL mid_reset_outputs got %b/%b/%b exp 00000/0/0",
                                 w_cmds, bus.req_ready_o, bus.ref_done_o);
        end
        next_cycle();
        rst_n = 1'b1;
        set_req(1'b1, 1'b0, 16'h0056, 10'h002, 4'h1, 4'h1);
        settle();
        n_checks++;
        if (w_cmds !== 5'b10000 || bus.ra_o !== 16'h0056) begin
            n_errors++; $display("FAIL mid_reset_act got %b/%h exp %b/%h", w_cmds, bus.ra_o, 5'b10000, 16'h0056);
        end
        bus.act_gnt_i = 1'b1;
        next_cycle();
        bus.act_gnt_i = 1'b0;
    endtask

    task automatic test_page_idle();
        int first_pre;
        first_pre = -1;
        set_req(1'b0, 1'b0, 16'h0056, 10'h000, 4'h0, 4'h0);
        for (int k = 0; k < 100; k++) begin
            settle();
            if (bus.pre_req_o === 1'b1 && first_pre < 0) first_pre = k;
            next_cycle();
        end
        n_checks++;
`ifdef SAL_BK_PAGE_TIMEOUT_EN
        if (first_pre != 32) begin
            n_errors++; $display("FAIL page_timeout_pre got %0d exp %0d", first_pre, 32);
        end
`else
        if (first_pre != -1) begin
            n_errors++; $display("FAIL open_page_no_pre got %0d exp %0d", first_pre, -1);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_req(1'b0, 1'b0, 16'h0000, 10'h000, 4'h0, 4'h0);
        bus.ref_pend_i = 1'b0;
        bus.act_gnt_i  = 1'b0;
        bus.rd_gnt_i   = 1'b0;
        bus.wr_gnt_i   = 1'b0;
        bus.pre_gnt_i  = 1'b0;
        bus.ref_gnt_i  = 1'b0;
        bus.t_rcd_m1_i = 8'd3;
        bus.t_ras_m1_i = 8'd7;
        bus.t_rp_m1_i  = 8'd2;
        bus.t_rtp_m1_i = 8'd1;
        bus.t_wr_m1_i  = 8'd9;
        bus.t_rfc_m1_i = 8'd19;
        rst_n = 1'b0;
        #1;
        test_reset();
        test_stray_grant();
        test_read_closed();
        test_row_hit();
        test_row_miss();
        test_refresh();
        test_reset_mid();
        test_page_idle();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
